simple_adder_8bit: RTL and testbench
====================================

# simple_adder_8bit

Registered 8-bit binary adder with carry-in, carry-out and status flags, used as a leaf arithmetic block in datapaths that need a clocked add. It samples operands under a valid strobe, then presents the sum, the carry, the signed-overflow flag and the zero flag with a matching output valid. There is no backpressure: every accepted operation produces exactly one result.

## Interface
- `WIDTH`, default 8: operand width. Only 8 is supported and verified.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `in_valid`  in  1  operands are valid this cycle.
- `a`  in  8  operand A (unsigned / two's complement).
- `b`  in  8  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result registers hold a new result this cycle.
- `sum`  out  8  (a + b + cin) mod 256.
- `cout`  out  1  bit 8 of a + b + cin.
- `ovf`  out  1  signed overflow: a[7]==b[7] && sum[7]!=a[7].
- `zero`  out  1  sum == 8'h00.

## Operation
- Compute a 9-bit unsigned sum a + b + cin. `sum` takes bits [7:0] and `cout` takes bit 8.
- Build the carry chain explicitly from per-bit full adders: s_i = a_i^b_i^c_i, c_{i+1} = a_i&b_i | c_i&(a_i^b_i), with c_0 = cin. `ovf` = c_7 ^ c_8, which equals the formula in the port list.
- `ovf` is independent of `cout`. For example, 8'h7F+8'h01 sets ovf=1 and cout=0, and 8'hFF+8'h01 sets ovf=0 and cout=1.
- When `in_valid`=1 at a rising edge, `sum`, `cout`, `ovf` and `zero` load the new result and `out_valid` goes to 1 for that cycle.
- When `in_valid`=0 at a rising edge:
  - `out_valid` goes to 0.
  - `sum`, `cout`, `ovf` and `zero` hold their previous values.
- Operands are don't-care when `in_valid`=0, including X/Z. X on the operands must not propagate into the held outputs.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on the outputs after edge N, with `out_valid`=1 for exactly that cycle.
- Throughput is one operation per cycle. Back-to-back `in_valid` gives back-to-back results.
- Reset values: `out_valid`=0, `sum`=8'h00, `cout`=0, `ovf`=0, `zero`=0.
- Reset has priority over `in_valid`. If `rst` is asserted at an edge, the operation presented at that edge and any operation in flight are discarded and produce no `out_valid`.
- First operation after reset release: `in_valid` on the first edge with `rst`=0 is accepted normally.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `SIMPLE_ADDER_8BIT_INREG_EN`.
- Defined:
  - `a`, `b`, `cin` and `in_valid` pass through an input register stage before the adder.
  - Latency becomes 2 cycles and throughput stays 1 per cycle.
  - Reset clears the input stage: its valid and operands go to 0.
- Not defined: single output register stage with latency 1.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1 -> `out_valid`=0, `sum`=00, `cout`=`ovf`=`zero`=0 throughout.
- Basic: 05+03 cin0 -> sum 08 cout0. 0A+0B cin0 -> 15 cout0. 0F+0F cin1 -> 1F cout0. 00+00 cin1 -> 01 cout0 zero0. Each result appears 1 cycle later with `out_valid`=1, issued back-to-back.
- Carry/zero corners:
  - 00+00 cin0 -> 00, cout0, zero1.
  - FF+01 cin0 -> 00, cout1, zero1, ovf0.
  - FF+00 cin1 -> 00, cout1, zero1.
  - FF+FF cin0 -> FE, cout1.
  - FF+FF cin1 -> FF, cout1.
- Signed overflow: 7F+01 -> 80 cout0 ovf1. 80+80 -> 00 cout1 ovf1 zero1. 80+7F cin1 -> 00 cout1 ovf0.
- Hold and reset mid-stream:
  - After the result 15, drop `in_valid` for 3 cycles with X operands -> outputs stay 15 and `out_valid`=0.
  - Assert `rst` on the same edge as `in_valid`=1 -> no result is produced.
- Random: 1000 random a/b/cin with random `in_valid` gaps -> every result matches the 9-bit reference model, and the count of `out_valid` pulses equals the count of accepted operations.

Source files
------------

// File: rtl/simple_adder_8bit.sv
// simple_adder_8bit
//   Registered 8-bit adder with carry-in, carry-out, signed-overflow and zero
//   flags. Operands are taken when in_valid is high; the result and its flags
//   appear on the registered outputs with out_valid high for one cycle.
//   Outputs hold their last result while in_valid is low. There is no
//   backpressure.
//
//   Build option: SIMPLE_ADDER_8BIT_INREG_EN
//     undefined : one output register stage, latency 1
//     defined   : extra input register stage in front of the adder, latency 2
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid this cycle
//   a, b       in   operands (unsigned / two's complement)
//   cin        in   carry-in
//   out_valid  out  new result on the outputs this cycle
//   sum        out  (a + b + cin) mod 2^WIDTH
//   cout       out  carry out of the MSB
//   ovf        out  signed overflow
//   zero       out  sum == 0
module simple_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic             add_valid;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;

`ifdef SIMPLE_ADDER_8BIT_INREG_EN
  logic             valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  // Operands only load with a valid strobe so idle-cycle garbage never
  // enters the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
    end
  end

  assign add_valid = valid_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
`else
  assign add_valid = in_valid;
  assign add_a     = a;
  assign add_b     = b;
  assign add_cin   = cin;
`endif

  // Ripple-carry chain. carry_msb_in is the carry into the MSB; signed
  // overflow is that carry differing from the carry out of the MSB.
  logic [WIDTH-1:0] sum_c;
  logic             carry_msb_in;
  logic             carry_out;

  always_comb begin
    logic carry;
    sum_c        = '0;
    carry_msb_in = 1'b0;
    carry        = add_cin;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        carry_msb_in = carry;
      end
      sum_c[i] = add_a[i] ^ add_b[i] ^ carry;
      carry    = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
    end
    carry_out = carry;
  end

  // Result registers load only on a valid operation, so undefined operands
  // during idle cycles cannot reach the held outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= add_valid;
      if (add_valid) begin
        sum  <= sum_c;
        cout <= carry_out;
        ovf  <= carry_msb_in ^ carry_out;
        zero <= (sum_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_simple_adder_8bit.sv
module tb_simple_adder_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;

  simple_adder_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result packing: {sum[7:0], cout, ovf, zero}
  logic [10:0] sb[$];
  logic [10:0] last_exp;
  bit          mon_en;
  int          checks;
  int          failures;
  int          n_acc;
  int          n_pulse;

  initial begin
    checks   = 0;
    failures = 0;
    n_acc    = 0;
    n_pulse  = 0;
    mon_en   = 1'b0;
    last_exp = '0;
  end

  function automatic logic [10:0] model(input logic [7:0] ai, input logic [7:0] bi,
                                        input logic ci);
    logic [8:0] t;
    logic       o;
    t = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
    o = (ai[7] == bi[7]) && (t[7] != ai[7]);
    return {t[7:0], t[8], o, (t[7:0] == 8'h00)};
  endfunction

  // A reset edge discards everything in flight and returns outputs to zero.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      last_exp = '0;
      mon_en   = 1'b1;
    end
  end

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (out_valid) begin
        n_pulse++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid: out_valid=1 sum=%h with no result outstanding", sum);
        end else begin
          logic [10:0] e;
          e = sb.pop_front();
          last_exp = e;
          if ({sum, cout, ovf, zero} !== e) begin
            failures++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                     sum, cout, ovf, zero, e[10:3], e[2], e[1], e[0]);
          end
        end
      end else if ({sum, cout, ovf, zero} !== last_exp) begin
        failures++;
        $display("FAIL hold: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                 sum, cout, ovf, zero, last_exp[10:3], last_exp[2], last_exp[1], last_exp[0]);
      end
    end
  end

  task automatic drive(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       input logic [10:0] exp);
    in_valid = 1'b1;
    a        = ai;
    b        = bi;
    cin      = ci;
    if (!rst) begin
      sb.push_back(exp);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held for two edges with a valid operation presented.
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h05;
    b        = 8'h03;
    cin      = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Basic, back-to-back.       sum    c  o  z
    drive(8'h05, 8'h03, 1'b0, {8'h08, 3'b000});
    drive(8'h0A, 8'h0B, 1'b0, {8'h15, 3'b000});
    drive(8'h0F, 8'h0F, 1'b1, {8'h1F, 3'b000});
    drive(8'h00, 8'h00, 1'b1, {8'h01, 3'b000});

    // Carry / zero corners.
    drive(8'h00, 8'h00, 1'b0, {8'h00, 3'b001});
    drive(8'hFF, 8'h01, 1'b0, {8'h00, 3'b101});
    drive(8'hFF, 8'h00, 1'b1, {8'h00, 3'b101});
    drive(8'hFF, 8'hFF, 1'b0, {8'hFE, 3'b100});
    drive(8'hFF, 8'hFF, 1'b1, {8'hFF, 3'b100});

    // Signed overflow.
    drive(8'h7F, 8'h01, 1'b0, {8'h80, 3'b010});
    drive(8'h80, 8'h80, 1'b0, {8'h00, 3'b111});
    drive(8'h80, 8'h7F, 1'b1, {8'h00, 3'b101});

    // Hold with undefined operands after a result of 15.
    drive(8'h0A, 8'h0B, 1'b0, {8'h15, 3'b000});
    idle(3);
    idle(2);

    // Reset on the same edge as a valid operation: nothing comes out.
    rst = 1'b1;
    drive(8'h12, 8'h34, 1'b0, {8'h46, 3'b000});
    rst = 1'b0;
    // First edge after release is accepted normally.
    drive(8'h12, 8'h34, 1'b0, {8'h46, 3'b000});
    idle(3);

    // Random operations with random gaps.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, model(ra, rb, rc));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    checks++;
    if (n_pulse != n_acc) begin
      failures++;
      $display("FAIL pulse_count: out_valid pulses=%0d, accepted operations=%0d", n_pulse, n_acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
